// File: rtl/uart_rx_bram_loader.sv
// Purpose: receive 8N1 UART bytes and store them sequentially into the CA input-stream BRAM.
// Latency: the write strobe rises about 9.5 bit-times plus 3 clocks after the start-bit falling edge.
// Backpressure: none; the BRAM write port always accepts, and excess bytes only raise overflow.
module uart_rx_bram_loader #(
    parameter int          CLKS_PER_BIT = 5208,
    parameter int          ADDR_WIDTH   = 8,
    parameter logic [7:0]  END_BYTE     = 8'h0A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic                  load_start,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [7:0]            bram_wdata,
    output logic [ADDR_WIDTH:0]   byte_count,
    output logic                  load_done,
    output logic                  frame_err,
    output logic                  overflow
);

    // Timer only ever needs to reach CLKS_PER_BIT-1.
    localparam int                TW      = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]     HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]     FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    // Receiver state
    logic [1:0]      sync_q;
    logic            rx_s;
    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            stop_q, stop_d;

    // Loader state
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   count_inc;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;
    logic                  ovf_q, ovf_d;

    assign rx_s      = sync_q[1];
    assign count_inc = count_q + 1'b1;

    // Two-flop synchronizer for the asynchronous RX pin; resets to the idle-high level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            stop_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            stop_q    <= stop_d;
        end
    end

    // Receiver next state: start qualified at mid start bit, data/stop sampled one bit-time apart.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        stop_d    = stop_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    timer_d = '0;
                end
            end
            S_START: begin
                if (timer_q == HALF_M1) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    // A line that is high again at mid start bit was only a glitch.
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    stop_d  = rx_s;
                    state_d = S_COMMIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Loader registers: BRAM write port, count and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Commit decision; a rearm pulse wins over a commit landing in the same cycle.
    always_comb begin
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        done_d  = done_q;
        ferr_d  = ferr_q;
        ovf_d   = ovf_q;
        if (load_start) begin
            count_d = '0;
            done_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == S_COMMIT) begin
            if (!stop_q) begin
                ferr_d = 1'b1;
            end else if (done_q) begin
                ovf_d = 1'b1;
            end else if (shift_q == END_BYTE) begin
                done_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_WIDTH-1:0];
                wdata_d = shift_q;
                count_d = count_inc;
                // Full memory ends the load so the address can never wrap.
                if (count_inc == CAPACITY) begin
                    done_d = 1'b1;
                end
            end
        end
    end

    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;
    assign byte_count = count_q;
    assign load_done  = done_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

endmodule
